// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and bit-mixing functions used by the
// message scheduler and the compression core.
package sha256_pkg;

  localparam int unsigned SHA_WORD_W = 32;
  localparam int unsigned SHA_BLK_W  = 512;
  localparam int unsigned NUM_ROUNDS = 64;
  localparam int unsigned WIN_WORDS  = 16;

  typedef logic [SHA_WORD_W-1:0] word_t;
  typedef logic [5:0]            round_t;

  localparam round_t T_LAST = round_t'(NUM_ROUNDS - 1);

  typedef enum logic {IDLE, RUN} sched_state_t;

  // H0[0] is the first initial hash word (a).
  localparam logic [7:0][SHA_WORD_W-1:0] H0 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  function automatic word_t ROTR(input word_t x, input int unsigned n);
    return (x >> n) | (x << (SHA_WORD_W - n));
  endfunction

  function automatic word_t sig0(input word_t x);
    return ROTR(x, 7) ^ ROTR(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return ROTR(x, 17) ^ ROTR(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t S0(input word_t x);
    return ROTR(x, 2) ^ ROTR(x, 13) ^ ROTR(x, 22);
  endfunction

  function automatic word_t S1(input word_t x);
    return ROTR(x, 6) ^ ROTR(x, 11) ^ ROTR(x, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// One message-expansion step: W[t+16] from W[t+14], W[t+9], W[t+1], W[t].
module sha256_w_expand
  import sha256_pkg::*;
(
  input  word_t w_tm2_i,
  input  word_t w_tm7_i,
  input  word_t w_tm15_i,
  input  word_t w_tm16_i,
  output word_t w_new_o
);

  always_comb begin
    w_new_o = sig1(w_tm2_i) + w_tm7_i + sig0(w_tm15_i) + w_tm16_i;
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: takes a 512-bit block and streams W[0..63]
// through a 16-word sliding window, with zero-bubble back-to-back blocks.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [SHA_BLK_W-1:0] blk_data,
  input  logic                 blk_last,
  input  logic                 flush,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [SHA_WORD_W-1:0] w_out,
  output logic [5:0]           w_idx,
  output logic                 w_last_blk,
  output logic                 blk_done
);

  sched_state_t state_q, state_d;
  logic [WIN_WORDS-1:0][SHA_WORD_W-1:0] win_q, win_d;
  round_t t_q, t_d;
  logic   last_q, last_d;

  logic  run, beat, at_last, take;
  word_t w_new;

  sha256_w_expand u_expand (
    .w_tm2_i  (win_q[WIN_WORDS-2]),
    .w_tm7_i  (win_q[WIN_WORDS-7]),
    .w_tm15_i (win_q[1]),
    .w_tm16_i (win_q[0]),
    .w_new_o  (w_new)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    t_d     = t_q;
    last_d  = last_q;

    run     = (state_q == RUN);
    beat    = run & w_ready;
    at_last = (t_q == T_LAST);

    w_valid    = run;
    w_out      = run ? win_q[0] : '0;
    w_idx      = t_q;
    w_last_blk = last_q;
    // A new block may only enter when the final word is leaving this cycle.
    blk_ready  = ~flush & (~run | (at_last & w_ready));
    blk_done   = beat & at_last & ~flush;
    take       = blk_valid & blk_ready;

    if (flush) begin
      state_d = IDLE;
      t_d     = '0;
    end else if (take) begin
      for (int unsigned i = 0; i < WIN_WORDS; i++) begin
        win_d[i] = blk_data[SHA_BLK_W-1-SHA_WORD_W*i -: SHA_WORD_W];
      end
      t_d     = '0;
      last_d  = blk_last;
      state_d = RUN;
    end else if (beat) begin
      if (at_last) begin
        state_d = IDLE;
        t_d     = '0;
      end else begin
        for (int unsigned i = 0; i < WIN_WORDS - 1; i++) begin
          win_d[i] = win_q[i+1];
        end
        win_d[WIN_WORDS-1] = w_new;
        t_d = t_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      t_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      t_q     <= t_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched against a full 64-word reference schedule.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         reset, blk_valid, blk_ready, blk_last, flush;
  logic         w_valid, w_ready, w_last_blk, blk_done;
  logic [511:0] blk_data;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;

  always #5 clk = ~clk;

  sha256_msg_sched dut (
    .clk        (clk),
    .reset      (reset),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .blk_last   (blk_last),
    .flush      (flush),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_out      (w_out),
    .w_idx      (w_idx),
    .w_last_blk (w_last_blk),
    .blk_done   (blk_done)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] obs[64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  // Reference: the full W[0..63] array straight from the recurrence.
  task automatic push_block(input logic [511:0] d, input logic last);
    logic [31:0] w[64];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = d[511-32*t -: 32];
      else        w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
      sb.push_back('{w: w[t], idx: 6'(t), last: last});
    end
  endtask

  function automatic logic rdy(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 2) == 0);
    return 1'(($urandom_range(0, 1)));
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Monitor: sample at negedge+3, pop on each beat.
  initial begin
    logic        ps;
    logic [31:0] po;
    logic [5:0]  pi;
    exp_t        e;
    ps = 1'b0; po = '0; pi = '0;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        ps = 1'b0;
        continue;
      end
      if (ps && w_valid) begin
        check("stall_w_out", w_out, po);
        check("stall_w_idx", w_idx, pi);
      end
      if (w_valid && w_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", w_valid, 0);
        end else begin
          e = sb.pop_front();
          check("w_out", w_out, e.w);
          check("w_idx", w_idx, e.idx);
          check("w_last_blk", w_last_blk, e.last);
          check("blk_done", blk_done, e.idx == 6'd63);
          obs[e.idx] = w_out;
        end
      end else if (blk_done) begin
        check("spurious_blk_done", blk_done, 0);
      end
      ps = w_valid && !w_ready;
      po = w_out;
      pi = w_idx;
    end
  end

  task automatic offer(input logic [511:0] d, input logic last, input int mode);
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      blk_valid = 1'b1; blk_data = d; blk_last = last; w_ready = rdy(mode);
      #1;
      if (blk_ready) begin
        push_block(d, last);
        done = 1;
      end
    end
    if (!done) check("accept_timeout", blk_ready, 1);
  endtask

  task automatic drain(input int mode);
    bit done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      blk_valid = 1'b0; w_ready = rdy(mode);
      #1;
      if (sb.size() == 0 && !w_valid) done = 1;
    end
    if (!done) check("drain_timeout", sb.size(), 0);
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 64; i++) obs[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] abc, blk_a, blk_b;
    bit           hit;

    reset = 1'b1; flush = 1'b0; blk_valid = 1'b0; w_ready = 1'b0;
    blk_data = '0; blk_last = 1'b0;
    #2;
    check("rst_w_valid", w_valid, 0);
    check("rst_blk_ready", blk_ready, 1);
    check("rst_w_out", w_out, 0);
    check("rst_w_idx", w_idx, 0);
    check("rst_w_last_blk", w_last_blk, 0);
    check("rst_blk_done", blk_done, 0);
    @(negedge clk); #1;
    reset = 1'b0;

    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;

    // "abc", continuous ready
    clear_obs();
    offer(abc, 1'b1, 0);
    drain(0);
    check("abc_W0", obs[0], 32'h61626380);
    check("abc_W15", obs[15], 32'h00000018);
    check("abc_W16", obs[16], 32'h61626380);
    check("abc_W17", obs[17], 32'h000F0000);

    // "abc", sparse ready
    clear_obs();
    offer(abc, 1'b0, 1);
    drain(1);
    check("abc_stall_W16", obs[16], 32'h61626380);
    check("abc_stall_W17", obs[17], 32'h000F0000);

    // back-to-back blocks
    blk_a = rand_block();
    blk_b = rand_block();
    offer(blk_a, 1'b0, 0);
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      blk_valid = 1'b1; blk_data = blk_b; blk_last = 1'b1; w_ready = 1'b1;
      #1;
      if (blk_ready) begin
        check("b2b_accept_idx", w_idx, 63);
        check("b2b_accept_done", blk_done, 1);
        push_block(blk_b, 1'b1);
        hit = 1;
      end
    end
    if (!hit) check("b2b_timeout", blk_ready, 1);
    @(negedge clk);
    blk_valid = 1'b0; w_ready = 1'b1;
    #1;
    check("b2b_next_valid", w_valid, 1);
    check("b2b_next_idx", w_idx, 0);
    drain(0);

    // flush at t=20 with a block offered
    blk_a = rand_block();
    blk_b = rand_block();
    offer(blk_a, 1'b1, 0);
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      blk_valid = 1'b0; w_ready = 1'b1;
      #1;
      if (w_valid && w_idx == 6'd20) begin
        flush = 1'b1; w_ready = 1'b0; blk_valid = 1'b1; blk_data = blk_b; blk_last = 1'b0;
        #1;
        check("flush_blk_ready", blk_ready, 0);
        check("flush_blk_done", blk_done, 0);
        sb.delete();
        hit = 1;
      end
    end
    if (!hit) check("flush_reach_t20", w_idx, 20);
    @(negedge clk);
    flush = 1'b0; blk_valid = 1'b0; w_ready = 1'b1;
    #1;
    check("post_flush_w_valid", w_valid, 0);
    check("post_flush_blk_done", blk_done, 0);
    check("post_flush_blk_ready", blk_ready, 1);
    offer(blk_b, 1'b0, 0);
    @(negedge clk);
    blk_valid = 1'b0; w_ready = 1'b1;
    #1;
    check("restart_w_idx", w_idx, 0);
    check("restart_w_valid", w_valid, 1);
    drain(2);

    // async reset at t=37
    blk_a = rand_block();
    offer(blk_a, 1'b1, 0);
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      blk_valid = 1'b0; w_ready = 1'b1;
      #1;
      if (w_valid && w_idx == 6'd37) begin
        #1;
        reset = 1'b1;
        #1;
        check("arst_w_valid", w_valid, 0);
        check("arst_w_out", w_out, 0);
        check("arst_w_idx", w_idx, 0);
        check("arst_w_last_blk", w_last_blk, 0);
        check("arst_blk_ready", blk_ready, 1);
        sb.delete();
        #1;
        reset = 1'b0;
        hit = 1;
      end
    end
    if (!hit) check("arst_reach_t37", w_idx, 37);
    @(negedge clk);
    w_ready = 1'b1;
    #1;
    check("post_arst_blk_ready", blk_ready, 1);
    check("post_arst_w_valid", w_valid, 0);

    // random blocks and blk_last patterns
    for (int n = 0; n < 8; n++) begin
      offer(rand_block(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      drain(int'($urandom_range(0, 2)));
    end

    check("sb_empty_at_end", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
